// File: rtl/mac_result_drain.sv
// Drains a captured snapshot of MAC accumulators: requantize (>>> then saturate) and stream one lane per cycle.
// Optional: define DRAIN_RELU_EN to clamp negative shifted values to zero before saturation.

module mac_drain_requant #(
    parameter int AW = 16,
    parameter int IW = 4,
    parameter int SW = 4
) (
    input  logic [AW-1:0] acc,
    input  logic [SW-1:0] shift,
    output logic [IW-1:0] q
);
    localparam logic signed [AW-1:0] QMAX = AW'((2 ** (IW - 1)) - 1);
`ifndef DRAIN_RELU_EN
    localparam logic signed [AW-1:0] QMIN = ~QMAX;
`endif

    logic signed [AW-1:0] t;

    // Arithmetic shift sign-fills, so oversized shifts collapse to 0 or -1.
    assign t = $signed(acc) >>> shift;

    always_comb begin
        q = t[IW-1:0];
`ifdef DRAIN_RELU_EN
        if (t[AW-1])
            q = '0;
        else if (t > QMAX)
            q = QMAX[IW-1:0];
`else
        if (t > QMAX)
            q = QMAX[IW-1:0];
        else if (t < QMIN)
            q = QMIN[IW-1:0];
`endif
    end
endmodule

module mac_result_drain #(
    parameter int ARRAY_SIZE             = 2,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int INPUT_DATA_WIDTH       = 4,
    parameter int SHIFT_WIDTH            = 4,
    localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cap_valid,
    output logic                                         cap_ready,
    input  logic [ARRAY_SIZE*ACCUMULATOR_DATA_WIDTH-1:0] acc_in,
    input  logic [SHIFT_WIDTH-1:0]                       shift_amt,
    output logic                                         acc_clear,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [INPUT_DATA_WIDTH-1:0]                  out_data,
    output logic [IDX_W-1:0]                             out_index,
    output logic                                         out_last
);
    localparam int AW = ACCUMULATOR_DATA_WIDTH;
    localparam int IW = INPUT_DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                        state, state_n;
    logic [IDX_W-1:0]              cnt, cnt_n;
    logic [ARRAY_SIZE-1:0][AW-1:0] snap;
    logic [SHIFT_WIDTH-1:0]        shift_q;
    logic [ARRAY_SIZE-1:0][IW-1:0] lane_q;
    logic                          last, capture, clr_q;

    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        mac_drain_requant #(.AW(AW), .IW(IW), .SW(SHIFT_WIDTH)) u_rq (
            .acc  (snap[g]),
            .shift(shift_q),
            .q    (lane_q[g])
        );
    end

    assign last      = (state == DRAIN) && (cnt == LAST_IDX);
    assign out_valid = (state == DRAIN);
    assign out_last  = last;
    assign out_index = cnt;
    assign out_data  = out_valid ? lane_q[cnt] : '0;
    // Opening on the final-lane handshake lets the next snapshot follow with no bubble.
    assign cap_ready = (state == IDLE) || (out_ready && last);
    assign capture   = cap_valid && cap_ready;
    assign acc_clear = clr_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (!last) begin
                        cnt_n = cnt + IDX_W'(1);
                    end else begin
                        cnt_n   = '0;
                        state_n = capture ? DRAIN : IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Reset takes priority, so a capture coinciding with reset never raises acc_clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            snap    <= '0;
            shift_q <= '0;
            clr_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            clr_q <= capture;
            if (capture) begin
                snap    <= acc_in;
                shift_q <= shift_amt;
            end
        end
    end
endmodule

// File: tb/tb_mac_result_drain.sv
// Checks mac_result_drain against a queue-based model plus hand-computed expectations.
module tb_mac_result_drain;
    localparam int AS = 2;
    localparam int AW = 16;
    localparam int IW = 4;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cap_valid = 1'b0;
    logic              cap_ready;
    logic [AS*AW-1:0]  acc_in = '0;
    logic [SW-1:0]     shift_amt = '0;
    logic              acc_clear;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IW-1:0]     out_data;
    logic [0:0]        out_index;
    logic              out_last;

    int nchk = 0;
    int nerr = 0;

    // Model: the list of (data, index, last) still owed by the drain.
    int qd[$];
    int qi[$];
    int ql[$];
    bit clr_exp = 1'b0;

    mac_result_drain #(
        .ARRAY_SIZE(AS), .ACCUMULATOR_DATA_WIDTH(AW),
        .INPUT_DATA_WIDTH(IW), .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_ready(cap_ready),
        .acc_in(acc_in), .shift_amt(shift_amt), .acc_clear(acc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic int rq(input logic [AW-1:0] a, input int s);
        int t;
        t = int'($signed(a)) >>> s;
`ifdef DRAIN_RELU_EN
        if (t < 0) t = 0;
`endif
        if (t > 7) t = 7;
        if (t < -8) t = -8;
        return t;
    endfunction

    function automatic int relu_exp(input int v);
`ifdef DRAIN_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dsig();
        return int'($signed(out_data));
    endfunction

    // Compare all outputs against the model, away from the active edge.
    task automatic sample();
        bit ev;
        @(negedge clk);
        ev = (qd.size() > 0);
        chk("out_valid", int'(out_valid), int'(ev));
        chk("cap_ready", int'(cap_ready), int'(qd.size() == 0 || (qd.size() == 1 && out_ready)));
        chk("acc_clear", int'(acc_clear), int'(clr_exp));
        if (ev) begin
            chk("out_data", dsig(), qd[0]);
            chk("out_index", int'(out_index), qi[0]);
            chk("out_last", int'(out_last), ql[0]);
        end else begin
            chk("idle_data", dsig(), 0);
            chk("idle_index", int'(out_index), 0);
            chk("idle_last", int'(out_last), 0);
        end
    endtask

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        bit hs, cr, cap;
        @(posedge clk);
        if (rst) begin
            qd.delete(); qi.delete(); ql.delete();
            clr_exp = 1'b0;
        end else begin
            hs  = (qd.size() > 0) && out_ready;
            cr  = (qd.size() == 0) || (qd.size() == 1 && out_ready);
            cap = cap_valid && cr;
            if (hs) begin
                void'(qd.pop_front()); void'(qi.pop_front()); void'(ql.pop_front());
            end
            if (cap)
                for (int i = 0; i < AS; i++) begin
                    qd.push_back(rq(acc_in[i*AW +: AW], int'(shift_amt)));
                    qi.push_back(i);
                    ql.push_back(int'(i == AS - 1));
                end
            clr_exp = cap;
        end
        #1;
    endtask

    task automatic lit(input string nm, input int v, input int d, input int idx, input int l);
        chk({nm, "_v"}, int'(out_valid), v);
        if (v != 0) begin
            chk({nm, "_d"}, dsig(), d);
            chk({nm, "_i"}, int'(out_index), idx);
            chk({nm, "_l"}, int'(out_last), l);
        end
    endtask

    // Capture two lanes with out_ready high and pin both outputs to literals.
    task automatic snap2(input string nm, input int a0, input int a1, input int s,
                         input int e0, input int e1);
        cap_valid = 1'b1; out_ready = 1'b1;
        acc_in = {16'(a1), 16'(a0)}; shift_amt = SW'(s);
        sample(); tick();
        cap_valid = 1'b0;
        sample(); lit({nm, "0"}, 1, e0, 0, 0); chk({nm, "_clr"}, int'(acc_clear), 1); tick();
        sample(); lit({nm, "1"}, 1, e1, 1, 1); chk({nm, "_clr1"}, int'(acc_clear), 0); tick();
        sample(); lit({nm, "_end"}, 0, 0, 0, 0); tick();
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick();
        sample();
        chk("rst_cap_ready", int'(cap_ready), 1);
        chk("rst_acc_clear", int'(acc_clear), 0);
        lit("rst", 0, 0, 0, 0);
        chk("rst_data", dsig(), 0);
        rst = 1'b0;
        tick();

        snap2("basic",  5,   -3,  0, 5, relu_exp(-3));
        snap2("sat",    100, -100, 0, 7, relu_exp(-8));
        snap2("shift3", 40,  -40, 3, 5, relu_exp(-5));
        snap2("shift15", -1, 1000, 15, relu_exp(-1), 0);
        snap2("relu",   -3,  20,  0, relu_exp(-3), 7);

        // Backpressure: first lane must hold for three stalled cycles.
        cap_valid = 1'b1; out_ready = 1'b0; acc_in = {16'd2, 16'd6}; shift_amt = '0;
        sample(); tick();
        cap_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample(); lit("hold", 1, 6, 0, 0); tick();
        end
        out_ready = 1'b1;
        sample(); lit("bp0", 1, 6, 0, 0); tick();
        sample(); lit("bp1", 1, 2, 1, 1); tick();
        sample(); lit("bp_end", 0, 0, 0, 0); tick();

        // Back-to-back snapshots with cap_valid held high.
        cap_valid = 1'b1; acc_in = {16'd2, 16'd1};
        sample(); tick();
        acc_in = {16'd4, 16'd3};
        sample(); lit("b2b0", 1, 1, 0, 0); chk("b2b_cr0", int'(cap_ready), 0);
        chk("b2b_clr0", int'(acc_clear), 1); tick();
        sample(); lit("b2b1", 1, 2, 1, 1); chk("b2b_cr1", int'(cap_ready), 1); tick();
        cap_valid = 1'b0;
        sample(); lit("b2b2", 1, 3, 0, 0); chk("b2b_clr2", int'(acc_clear), 1); tick();
        sample(); lit("b2b3", 1, 4, 1, 1); tick();
        sample(); lit("b2b_end", 0, 0, 0, 0); tick();

        // Reset mid-drain drops the second lane.
        cap_valid = 1'b1; acc_in = {16'd7, 16'd7};
        sample(); tick();
        cap_valid = 1'b0;
        sample(); lit("mr0", 1, 7, 0, 0); tick();
        rst = 1'b1;
        sample(); tick();
        rst = 1'b0;
        sample(); lit("mr_after", 0, 0, 0, 0); chk("mr_cr", int'(cap_ready), 1); tick();
        sample(); lit("mr_after2", 0, 0, 0, 0); tick();

        // Capture coinciding with reset must not pulse acc_clear.
        cap_valid = 1'b1; rst = 1'b1;
        sample(); tick();
        cap_valid = 1'b0; rst = 1'b0;
        sample(); chk("rstcap_clr", int'(acc_clear), 0); lit("rstcap", 0, 0, 0, 0); tick();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cap_valid = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            shift_amt = SW'($urandom_range(0, 15));
            for (int i = 0; i < AS; i++)
                acc_in[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom)
                                   : AW'($urandom_range(0, 400) - 200);
            rst = ($urandom_range(0, 59) == 0);
            sample(); tick();
        end
        rst = 1'b0; cap_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            sample(); tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Consumer end of the mac_array accumulator interface.
- Snapshots all ARRAY_SIZE accumulators in one capture handshake, then requantizes each one: arithmetic right shift, then saturation to INPUT_DATA_WIDTH.
- Streams the results out one per cycle on a valid/ready port, toward the activation buffer or the host readback path.
- Pulses acc_clear on capture so the MAC array can start the next tile while the drain runs.

Parameters:
- ARRAY_SIZE, 2, number of MAC lanes captured per snapshot.
- ACCUMULATOR_DATA_WIDTH, 16, width of each signed accumulator.
- INPUT_DATA_WIDTH, 4, width of each signed requantized output.
- SHIFT_WIDTH, 4, width of the shift-amount port; must satisfy 2^SHIFT_WIDTH >= ACCUMULATOR_DATA_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cap_valid  in  1  accumulators are final and may be captured.
- cap_ready  out  1  drain can accept a snapshot.
- acc_in  in  ARRAY_SIZE*ACCUMULATOR_DATA_WIDTH  packed accumulators; lane i at bits [i*ACCUMULATOR_DATA_WIDTH +: ACCUMULATOR_DATA_WIDTH].
- shift_amt  in  SHIFT_WIDTH  right-shift amount, sampled at capture.
- acc_clear  out  1  one-cycle pulse telling mac_array to zero its accumulators.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  INPUT_DATA_WIDTH  signed requantized lane value.
- out_index  out  $clog2(ARRAY_SIZE) (min 1)  lane number of out_data.
- out_last  out  1  high with the final lane of a snapshot.

Behaviour:
- Reset (rst=1 at a clk edge) forces state IDLE and lane counter 0.
  - Outputs after reset: cap_ready=1, out_valid=0, acc_clear=0, out_last=0, out_index=0, out_data=0.
  - Snapshot buffer and latched shift are cleared to 0.
- Capture handshake: cap_valid && cap_ready at a clk edge.
  - Latches every lane of acc_in and shift_amt.
  - Drives acc_clear=1 for exactly the next cycle.
  - Moves to DRAIN with counter=0.
- State machine:
  - IDLE: cap_ready=1, out_valid=0. On capture -> DRAIN.
  - DRAIN: out_valid=1; out_index=counter; out_data=requant(lane[counter]); out_last=(counter==ARRAY_SIZE-1).
  - DRAIN, on out_valid && out_ready with out_last=0: counter+1, stay in DRAIN.
  - DRAIN, on out_valid && out_ready with out_last=1:
    - with cap_valid=1: capture the new snapshot in the same edge, counter=0, stay in DRAIN (back-to-back, no bubble).
    - otherwise: go to IDLE.
- cap_ready in DRAIN = out_ready && out_last. This is combinational and only permitted on the final-lane handshake.
- Latency:
  - First output is valid the cycle after capture.
  - Minimum ARRAY_SIZE cycles per snapshot.
  - Full throughput with out_ready held high.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable. No lane is skipped or duplicated.
- Requant arithmetic:
  - t = lane >>> shift, signed arithmetic shift, truncating toward negative infinity.
  - Saturate t to [-2^(INPUT_DATA_WIDTH-1), 2^(INPUT_DATA_WIDTH-1)-1].
  - shift=0 passes the value through unshifted.
  - shift >= ACCUMULATOR_DATA_WIDTH yields 0 for non-negative lanes and -1 for negative lanes.
- cap_valid while in DRAIN and not on the last handshake is ignored (cap_ready=0); the source must hold it.
- Reset asserted mid-drain abandons the snapshot. No further outputs appear, and any acc_clear pulse in flight is suppressed.
- ARRAY_SIZE=1: every output has out_last=1; out_index stays 0.

Optional Feature:
- Macro: DRAIN_RELU_EN.
- Defined: ReLU is applied after the shift and before saturation, so negative t becomes 0; the output range is [0, 2^(INPUT_DATA_WIDTH-1)-1].
- Undefined: signed saturation only, with no ReLU logic present.

Test Plan:
- Defaults; acc_in lanes {5,-3}, shift 0, out_ready=1 -> cycle+1: data 5, idx 0, last 0; cycle+2: data -3, idx 1, last 1; acc_clear pulses once, on cycle+1.
- Lanes {100,-100}, shift 0 -> outputs 7, -8 (saturation); lanes {40,-40}, shift 3 -> 5, -5; lane -1, shift 15 -> -1.
- Lanes {6,2}, out_ready low 3 cycles after capture -> out_data=6, idx 0 held for 3 cycles; then 6, 2 are each delivered exactly once.
- Back-to-back: cap_valid held high with lanes {1,2} then {3,4} -> stream 1, 2, 3, 4 with no idle cycle; second capture on the idx-1 handshake; two acc_clear pulses.
- rst asserted after the first lane of {7,7} is accepted -> next cycle out_valid=0, cap_ready=1; the second lane is never emitted.
- DRAIN_RELU_EN defined; lanes {-3,20}, shift 0 -> outputs 0, 7.
